// File: rtl/sram_controller.sv
// Purpose: services one 32-bit MEM-stage load/store as two 16-bit accesses on an async SRAM.
// Latency: ready low for 3+WAIT_CYCLES cycles from the request, then high for one DONE cycle.
// Backpressure: ready drops combinationally while a request is pending; the pipeline freezes on ~ready.
module sram_controller #(
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOW  = 3'd1,
    S_HIGH = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Last counter value spent in WAIT; only meaningful when WAIT_CYCLES > 0.
  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_wr_q, op_wr_d;
  logic [16:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] read_data_q, read_data_d;

  logic        req;
  logic [31:0] offset;
  logic        unused_addr_bits;
  logic        dq_oe;
  logic [15:0] dq_out;

  assign req    = wr_en | rd_en;
  assign offset = address - ADDR_BASE;
  // Word-aligned byte offset: the low two bits and bits above the 17-bit word index are ignored.
  assign unused_addr_bits = ^{offset[31:19], offset[1:0]};

  assign ready     = ~(req & (state_q != S_DONE));
  assign read_data = read_data_q;

  assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  // State and datapath registers; reset drops straight back to an idle bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      op_wr_q     <= 1'b0;
      idx_q       <= 17'd0;
      wdata_q     <= 32'd0;
      read_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_wr_q     <= op_wr_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
    end
  end

  // Next state: latch the request when leaving IDLE, capture load halves as LOW/HIGH close.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_wr_d     = op_wr_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_LOW;
          op_wr_d = wr_en;  // write wins when both enables are high
          idx_d   = offset[18:2];
          wdata_d = write_data;
        end
      end
      S_LOW: begin
        state_d = S_HIGH;
        if (!op_wr_q) read_data_d[15:0] = SRAM_DQ;
      end
      S_HIGH: begin
        state_d = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
        cnt_d   = 4'd0;
        if (!op_wr_q) read_data_d[31:16] = SRAM_DQ;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == WAIT_LAST) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs decoded from state; only LOW/HIGH touch the SRAM.
  always_comb begin
    SRAM_ADDR = 18'd0;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = 16'd0;
    case (state_q)
      S_LOW, S_HIGH: begin
        SRAM_ADDR = {idx_q, (state_q == S_HIGH)};
        if (op_wr_q) begin
          SRAM_WE_N = 1'b0;
          dq_oe     = 1'b1;
          dq_out    = (state_q == S_HIGH) ? wdata_q[31:16] : wdata_q[15:0];
        end else begin
          SRAM_OE_N = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
// Purpose: randomized and directed stimulus for sram_controller against a word-level memory model.
// Latency: expects ready low for 3+WAIT_CYCLES cycles per access and one ready-high DONE cycle.
// Backpressure: holds each request until ready rises, then releases it.
module tb_sram_controller;

  localparam int WAIT_CYCLES = 2;
  localparam int LOW_CYCLES  = 3 + WAIT_CYCLES;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N;
  logic        SRAM_OE_N;
  logic        SRAM_CE_N;
  logic        SRAM_UB_N;
  logic        SRAM_LB_N;

  sram_controller #(.ADDR_BASE(1024), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_DQ    (SRAM_DQ),
    .SRAM_ADDR  (SRAM_ADDR),
    .SRAM_WE_N  (SRAM_WE_N),
    .SRAM_OE_N  (SRAM_OE_N),
    .SRAM_CE_N  (SRAM_CE_N),
    .SRAM_UB_N  (SRAM_UB_N),
    .SRAM_LB_N  (SRAM_LB_N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical SRAM: drives the bus on reads, stores on write-enable cycles.
  logic [15:0] mem [0:1023];
  assign SRAM_DQ = (!SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR[9:0]] : 16'hzzzz;

  // Bus monitor: every write-enable cycle and every output-enable cycle.
  logic [33:0] got_q[$];
  int          oe_cnt;
  int          overlap_cnt;
  always @(posedge clk) begin
    if (!SRAM_WE_N) begin
      got_q.push_back({SRAM_ADDR, SRAM_DQ});
      mem[SRAM_ADDR[9:0]] <= SRAM_DQ;
    end
    if (!SRAM_OE_N) oe_cnt++;
    if (!SRAM_WE_N && !SRAM_OE_N) overlap_cnt++;
  end

  // Reference model: word-addressed memory and last loaded value.
  logic [31:0] ref_mem [0:255];
  logic [31:0] ref_rdata;

  int n_chk;
  int n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Count ready-low cycles until ready rises; called just after inputs settle in the request cycle.
  task automatic wait_done(output int low, output bit done);
    low  = 0;
    done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (ready) begin
        done = 1'b1;
        break;
      end
      low++;
      @(negedge clk);
    end
  endtask

  // Completion checks shared by all accesses: latency, load data, bus activity.
  task automatic finish_access(input bit is_wr, input int idx, input logic [31:0] data);
    int low;
    bit done;
    wait_done(low, done);
    check("done_reached", 32'(done), 32'd1);
    check("ready_low_cycles", low, LOW_CYCLES);
    check("read_data", read_data, ref_rdata);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #1;
    check("ready_idle", 32'(ready), 32'd1);
    if (is_wr) begin
      check("we_pulses", got_q.size(), 2);
      if (got_q.size() >= 2) begin
        check("we_addr_lo", 32'(got_q[0][33:16]), 2 * idx);
        check("we_data_lo", 32'(got_q[0][15:0]), 32'(data[15:0]));
        check("we_addr_hi", 32'(got_q[1][33:16]), 2 * idx + 1);
        check("we_data_hi", 32'(got_q[1][15:0]), 32'(data[31:16]));
      end
      check("oe_during_write", oe_cnt, 0);
    end else begin
      check("we_during_read", got_q.size(), 0);
      check("oe_cycles", oe_cnt, 2);
    end
  endtask

  // One complete request; the model is updated at issue time.
  task automatic do_txn(input bit wr, input bit rd, input int idx, input logic [31:0] data);
    @(negedge clk);
    wr_en      = wr;
    rd_en      = rd;
    address    = 32'(1024 + 4 * idx);
    write_data = data;
    got_q.delete();
    oe_cnt = 0;
    if (wr) ref_mem[idx] = data;
    else    ref_rdata    = ref_mem[idx];
    finish_access(wr, idx, data);
  endtask

  initial begin
    int low;
    bit done;
    logic [31:0] d;
    n_chk = 0;
    n_err = 0;
    oe_cnt = 0;
    overlap_cnt = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    mem[0] = 16'hBEEF;
    mem[1] = 16'hDEAD;
    ref_mem[0] = 32'hDEADBEEF;
    ref_rdata  = 32'h0;
    rst = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    address = 32'd1024;
    write_data = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_we_n", 32'(SRAM_WE_N), 32'd1);
    check("rst_addr", 32'(SRAM_ADDR), 32'd0);
    rst = 1'b0;

    // Idle: nothing happens without a request.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("idle_ready", 32'(ready), 32'd1);
      check("idle_we_n", 32'(SRAM_WE_N), 32'd1);
      check("idle_oe_n", 32'(SRAM_OE_N), 32'd1);
      check("idle_read_data", read_data, 32'd0);
    end

    // Directed: preloaded load, store, address mapping, simultaneous enables.
    do_txn(1'b0, 1'b1, 0, 32'h0);
    check("load_preloaded", read_data, 32'hDEADBEEF);
    do_txn(1'b1, 1'b0, 0, 32'hDEADBEEF);
    do_txn(1'b1, 1'b0, 1, 32'h12345678);
    check("mem_hw2", 32'(mem[2]), 32'h5678);
    check("mem_hw3", 32'(mem[3]), 32'h1234);
    do_txn(1'b0, 1'b1, 1, 32'h0);
    check("load_1028", read_data, 32'h12345678);
    do_txn(1'b0, 1'b1, 0, 32'h0);
    check("load_1024_again", read_data, 32'hDEADBEEF);
    do_txn(1'b1, 1'b1, 7, 32'hA5A55A5A);
    check("both_keeps_rdata", read_data, 32'hDEADBEEF);
    check("both_mem_hw14", 32'(mem[14]), 32'h5A5A);

    // Reset during HIGH of a write, then restart with the request still held.
    d = 32'hCAFEF00D;
    @(negedge clk);
    wr_en      = 1'b1;
    address    = 32'(1024 + 4 * 5);
    write_data = d;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mid_we_in_high", 32'(SRAM_WE_N), 32'd0);
    check("mid_addr_high", 32'(SRAM_ADDR), 32'd11);
    rst = 1'b1;
    #1;
    check("mid_rst_we_n", 32'(SRAM_WE_N), 32'd1);
    check("mid_rst_oe_n", 32'(SRAM_OE_N), 32'd1);
    check("mid_rst_addr", 32'(SRAM_ADDR), 32'd0);
    check("mid_rst_ready", 32'(ready), 32'd0);
    ref_rdata = 32'h0;
    check("mid_rst_rdata", read_data, ref_rdata);
    @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    oe_cnt = 0;
    ref_mem[5] = d;
    finish_access(1'b1, 5, d);
    do_txn(1'b0, 1'b1, 5, 32'h0);
    check("mid_reload", read_data, d);

    // Randomized mix of loads, stores and dual-enable stores.
    for (int t = 0; t < 60; t++) begin
      int kind;
      int idx;
      kind = $urandom_range(0, 4);
      idx  = $urandom_range(0, 15);
      d    = $urandom;
      if (kind <= 1)      do_txn(1'b0, 1'b1, idx, d);
      else if (kind <= 3) do_txn(1'b1, 1'b0, idx, d);
      else                do_txn(1'b1, 1'b1, idx, d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Final sweep of the physical memory against the model.
    for (int i = 0; i < 16; i++) begin
      check("final_mem", {mem[2 * i + 1], mem[2 * i]}, ref_mem[i]);
    end
    check("we_oe_overlap", overlap_cnt, 0);

    low  = 0;
    done = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
